// File: rtl/e203_ifu_bpu_ctrl.sv
// e203_ifu_bpu_ctrl: registered BTFN branch prediction with JALR resolution (optional macro E203_IFU_JALR_XN_RD_EN)
module e203_ifu_bpu_ctrl #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ir_valid_i,
  output logic            ir_ready_o,
  input  logic [PC_W-1:0] pc_i,
  input  logic            dec_rv32,
  input  logic            dec_bjp,
  input  logic            dec_jal,
  input  logic            dec_jalr,
  input  logic            dec_bxx,
  input  logic [4:0]      dec_jalr_rs1idx,
  input  logic [PC_W-1:0] dec_bjp_imm,
  input  logic [PC_W-1:0] x1_val_i,
  input  logic            oitf_empty_i,
  input  logic            exu_ir_valid_i,
  input  logic            exu_ir_rdwen_i,
  input  logic [4:0]      exu_ir_rdidx_i,
  output logic            rs1_req_o,
  output logic [4:0]      rs1_idx_o,
  input  logic            rf_port_busy_i,
  input  logic [PC_W-1:0] rs1_rdata_i,
  input  logic            flush_i,
  output logic            prdt_valid_o,
  input  logic            prdt_ready_i,
  output logic            prdt_taken_o,
  output logic [PC_W-1:0] prdt_pc_o
);
`ifdef E203_IFU_JALR_XN_RD_EN
  typedef enum logic [2:0] {IDLE, WAIT_DEP, RD_REQ, RD_DATA, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, WAIT_DEP, DONE} state_e;
  logic unused_rd;
  assign unused_rd = ^{rs1_rdata_i, rf_port_busy_i};
`endif
  localparam logic [PC_W-1:0] ALIGN = ~PC_W'(1);
  state_e          state_q, state_d;
  logic [PC_W-1:0] imm_q, imm_d, pc_q, pc_d;
  logic            taken_q, taken_d;
  logic [4:0]      rs1_q, rs1_d;
  logic            accept, dep_new, dep_q;
  logic [PC_W-1:0] seq_pc, tgt_pc;
  assign ir_ready_o = ~flush_i & (state_q == IDLE | (state_q == DONE & prdt_ready_i));
  assign accept     = ir_valid_i & ir_ready_o;
  assign seq_pc     = pc_i + (dec_rv32 ? PC_W'(4) : PC_W'(2));
  assign tgt_pc     = pc_i + dec_bjp_imm;
  // The accept cycle already counts as a dependency-check cycle, so a clean JALR x1 resolves at T+1.
  assign dep_new    = ~oitf_empty_i | (exu_ir_valid_i & exu_ir_rdwen_i & exu_ir_rdidx_i == dec_jalr_rs1idx);
  assign dep_q      = ~oitf_empty_i | (exu_ir_valid_i & exu_ir_rdwen_i & exu_ir_rdidx_i == rs1_q);
  // State and prediction registers; reset clears every visible output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      imm_q   <= '0;
      pc_q    <= '0;
      taken_q <= 1'b0;
      rs1_q   <= '0;
    end else begin
      state_q <= state_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
      rs1_q   <= rs1_d;
    end
  end
  // Next state and prediction; flush beats everything, then accept, then per-state progress.
  always_comb begin
    state_d = state_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    taken_d = taken_q;
    rs1_d   = rs1_q;
    if (flush_i) state_d = IDLE;
    else if (accept) begin
      imm_d   = dec_bjp_imm;
      rs1_d   = dec_jalr_rs1idx;
      state_d = DONE;
      taken_d = 1'b0;
      pc_d    = seq_pc;
      if (dec_bjp & dec_jal) begin
        taken_d = 1'b1;
        pc_d    = tgt_pc;
      end else if (dec_bjp & dec_bxx) begin
        taken_d = dec_bjp_imm[PC_W-1];
        pc_d    = dec_bjp_imm[PC_W-1] ? tgt_pc : seq_pc;
      end else if (dec_bjp & dec_jalr & dec_jalr_rs1idx == 5'd0) begin
        taken_d = 1'b1;
        pc_d    = dec_bjp_imm & ALIGN;
      end else if (dec_bjp & dec_jalr & dec_jalr_rs1idx == 5'd1) begin
        if (dep_new) state_d = WAIT_DEP;
        else begin
          taken_d = 1'b1;
          pc_d    = (x1_val_i + dec_bjp_imm) & ALIGN;
        end
      end
`ifdef E203_IFU_JALR_XN_RD_EN
      else if (dec_bjp & dec_jalr) state_d = dep_new ? WAIT_DEP : RD_REQ;
`endif
    end else begin
      case (state_q)
        WAIT_DEP: if (!dep_q) begin
`ifdef E203_IFU_JALR_XN_RD_EN
          if (rs1_q != 5'd1) state_d = RD_REQ;
          else begin
`else
          begin
`endif
            state_d = DONE;
            taken_d = 1'b1;
            pc_d    = (x1_val_i + imm_q) & ALIGN;
          end
        end
`ifdef E203_IFU_JALR_XN_RD_EN
        RD_REQ: if (!rf_port_busy_i) state_d = RD_DATA;
        RD_DATA: begin
          state_d = DONE;
          taken_d = 1'b1;
          pc_d    = (rs1_rdata_i + imm_q) & ALIGN;
        end
`endif
        DONE: if (prdt_ready_i) state_d = IDLE;
        default: ;
      endcase
    end
  end
  // Outputs decoded from the registered state.
  always_comb begin
    prdt_valid_o = state_q == DONE;
    prdt_taken_o = taken_q;
    prdt_pc_o    = pc_q;
`ifdef E203_IFU_JALR_XN_RD_EN
    rs1_req_o    = state_q == RD_REQ;
    rs1_idx_o    = state_q == RD_REQ ? rs1_q : 5'd0;
`else
    rs1_req_o    = 1'b0;
    rs1_idx_o    = 5'd0;
`endif
  end
endmodule

// File: doc/e203_ifu_bpu_ctrl.md
# e203_ifu_bpu_ctrl

Sequential branch-prediction controller in the IFU. It sits behind the IFU mini-decoder (`dec_*` outputs) and, for each fetched instruction, produces a registered prediction: taken flag and next PC. It resolves JAL/Bxx/JALR targets and applies static backward-taken/forward-not-taken (BTFN) prediction for Bxx. For JALR it stalls on register dependencies and arbitrates for the shared regfile read port with the EXU.

## Interface
Parameters:
- `PC_W`, default 32: PC and immediate width.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `ir_valid_i` in 1, `ir_ready_o` out 1: instruction-in handshake.
- `pc_i` in PC_W: PC of the presented instruction.
- `dec_rv32`, `dec_bjp`, `dec_jal`, `dec_jalr`, `dec_bxx` in 1 each: mini-decoder classification.
- `dec_jalr_rs1idx` in 5: JALR rs1 index.
- `dec_bjp_imm` in PC_W: sign-extended branch/jump offset.
- `x1_val_i` in PC_W: forwarded x1 value.
- `oitf_empty_i` in 1: no outstanding long-pipeline writes.
- `exu_ir_valid_i` in 1, `exu_ir_rdwen_i` in 1, `exu_ir_rdidx_i` in 5: instruction currently in the EXU IR stage.
- `rs1_req_o` out 1: regfile read-port request.
- `rs1_idx_o` out 5: read index.
- `rf_port_busy_i` in 1: EXU owns the port this cycle.
- `rs1_rdata_i` in PC_W: read data, valid the cycle after grant.
- `flush_i` in 1: pipeline flush.
- `prdt_valid_o` out 1, `prdt_ready_i` in 1: prediction-out handshake.
- `prdt_taken_o` out 1, `prdt_pc_o` out PC_W: prediction result.

## Operation
- States: IDLE, WAIT_DEP, RD_REQ, RD_DATA, DONE.
- `ir_ready_o` = ~`flush_i` & (IDLE | (DONE & `prdt_ready_i`)).
- Accept = `ir_valid_i` & `ir_ready_o`. On accept, latch `pc_i`, `dec_*`, and imm, then classify:
  - Non-bjp: taken 0, next = pc + (rv32 ? 4 : 2). Go to DONE.
  - JAL: taken 1, next = pc + imm. Go to DONE.
  - Bxx: taken = imm[PC_W-1]. Next = taken ? pc+imm : pc+(rv32?4:2). Go to DONE.
  - JALR with rs1 = x0: taken 1, next = imm & ~1. Go to DONE.
  - JALR with rs1 = x1: go to WAIT_DEP.
  - JALR with rs1 = xn (n>1): go to WAIT_DEP.
- `dep` = ~`oitf_empty_i` | (`exu_ir_valid_i` & `exu_ir_rdwen_i` & `exu_ir_rdidx_i` == rs1).
- WAIT_DEP, when `dep` = 0:
  - x1: next = (`x1_val_i` + imm) & ~1, taken 1. Go to DONE.
  - xn: go to RD_REQ.
- RD_REQ: `rs1_req_o` = 1, `rs1_idx_o` = latched rs1.
  - Grant = `rs1_req_o` & ~`rf_port_busy_i`.
  - On grant go to RD_DATA; otherwise hold the request.
- RD_DATA: next = (`rs1_rdata_i` + imm) & ~1, taken 1. Go to DONE.
- DONE: `prdt_valid_o` = 1 and results hold stable until `prdt_ready_i`.
  - On `prdt_ready_i`: go to IDLE, or reload directly if a new accept happens that same cycle.
- All adds are PC_W-bit, modulo 2^PC_W; carry-out is discarded.

## Timing
- Reset (`rst_n`=0 at a clk edge): state IDLE; `prdt_valid_o`, `prdt_taken_o`, `prdt_pc_o`, `rs1_req_o`, `rs1_idx_o` all 0. `ir_ready_o` is 1 after reset.
- Latency from accept at cycle T:
  - Non-JALR or JALR x0: `prdt_valid_o` at T+1.
  - JALR x1: T+1+k, where k = cycles with `dep` = 1.
  - JALR xn: `rs1_req_o` at T+1+k. With grant at cycle G, `prdt_valid_o` at G+2.
- Throughput: one prediction per cycle when `prdt_ready_i` is held 1 and no JALR x1/xn instructions.
- `flush_i` has top priority in any state:
  - Next state is IDLE and `prdt_valid_o`/`rs1_req_o` drop next cycle.
  - No accept occurs in the flush cycle.
  - Read data arriving after a flush is ignored.
- Reset mid-operation behaves like flush; all outputs return to their reset values.
- `dep` and `rf_port_busy_i` are only sampled in WAIT_DEP and RD_REQ respectively.

## Configuration
- `E203_IFU_JALR_XN_RD_EN` defined: JALR with rs1 = xn uses the WAIT_DEP, RD_REQ, RD_DATA path described above.
- Undefined:
  - JALR xn predicts taken 0, next = pc + (rv32?4:2), and goes to DONE at T+1; the EXU corrects it.
  - `rs1_req_o` is tied to 0 and `rs1_idx_o` is tied to 0.
  - RD_REQ and RD_DATA are removed.

## Test plan
- Bxx, pc=0x100, imm=0xFFFFFFF0, rv32=1 -> T+1: taken=1, pc=0x0F0. Same with imm=0x20 -> taken=0, pc=0x104.
- JAL pc=0xFFFFFFFC, imm=8 -> taken=1, pc=0x4 (wrap). Then a 16-bit non-bjp at pc=0x200 accepted back-to-back with `prdt_ready_i`=1 -> taken=0, pc=0x202 on the next cycle.
- JALR rs1=x1, imm=3, x1=0x1000, with EXU IR writing x1 for 2 cycles -> `prdt_valid_o` at T+3, pc=0x1002.
- JALR rs1=x5, imm=0, `rf_port_busy_i`=1 for 3 cycles then 0, rdata=0x8001 -> `rs1_req_o` held 4 cycles with idx 5; pc=0x8000 two cycles after grant. With the macro undefined -> taken=0, pc=pc+4, `rs1_req_o` never asserted.
- `flush_i` during RD_REQ and during DONE with `prdt_ready_i`=0 -> IDLE next cycle, `prdt_valid_o`=0, no accept in the flush cycle.
- `rst_n`=0 during WAIT_DEP -> all outputs 0 next cycle, `ir_ready_o`=1 after `rst_n` is released.
